serial_datapath: RTL and testbench

- Bit-serial operand/result datapath, directly downstream of the control FSM.
- Consumes the FSM strobes: load_a, load_b, shift_a, shift_b, shift_out, alu_op, load_out and carry_en.
- Holds operands A and B, runs a 1-bit ALU over them LSB-first with a carry/borrow flop, and accumulates the result.
- Presents the result both in parallel and as an LSB-first serial stream during write-out.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/serial_alu_bit.sv | 34 +++
 rtl/serial_datapath.sv | 116 +++++++++++
 tb/tb_serial_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, opcodes, helpers.
// Imported by the serial datapath and the control FSM.
package cpu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // opcode[3]=1 selects R-type, 0 selects I-type (immediate)
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_SUBI = 4'b0001;
    localparam logic [3:0] OP_XORI = 4'b0010;
    localparam logic [3:0] OP_ANDI = 4'b0011;
    localparam logic [3:0] OP_ORI  = 4'b0100;

    function automatic logic is_sub(input logic [3:0] op);
        return op[2:0] == 3'b001;
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice for the bit-serial datapath.
// Subtraction inverts b; the caller seeds the carry with 1.
module serial_alu_bit
    import cpu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    input  logic       sub,
    output logic       s,
    output logic       cout
);

    logic w_b;

    assign w_b = b ^ (sub & (op == ALU_ADD));

    // select the bit result; non-arithmetic ops pass the carry through
    always_comb begin
        s    = 1'b0;
        cout = cin;
        unique case (op)
            ALU_ADD: begin
                s    = a ^ w_b ^ cin;
                cout = (a & w_b) | (a & cin) | (w_b & cin);
            end
            ALU_XOR: s = a ^ b;
            ALU_AND: s = a & b;
            ALU_OR:  s = a | b;
        endcase
    end

endmodule

// File: rtl/serial_datapath.sv
// Bit-serial operand/result datapath driven by the control FSM strobes.
// Operands shift out LSB-first through a 1-bit ALU into an accumulator.
module serial_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] imm_data,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             shift_a,
    input  logic             shift_b,
    input  logic [1:0]       alu_op,
    input  logic             carry_en,
    input  logic             load_out,
    input  logic             shift_out,
    output logic [WIDTH-1:0] result,
    output logic             serial_out,
    output logic             carry_flag,
    output logic             zero_flag
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zacc;
    logic             r_carry_flag;
    logic             r_zero_flag;

    logic w_sub;
    logic w_s;
    logic w_cout;

    assign w_sub = is_sub(opcode);

    serial_alu_bit u_alu (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .op   (alu_op),
        .sub  (w_sub),
        .s    (w_s),
        .cout (w_cout)
    );

    // operand A: parallel load wins over the serial shift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_a <= '0;
        else if (load_a)
            r_a <= a_data;
        else if (shift_a)
            r_a <= {1'b0, r_a[WIDTH-1:1]};
    end

    // operand B: immediate on I-type load_a, else b_data, else shift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_b <= '0;
        else if (load_a && !opcode[3])
            r_b <= imm_data;
        else if (load_b)
            r_b <= b_data;
        else if (shift_b)
            r_b <= {1'b0, r_b[WIDTH-1:1]};
    end

    // accumulator, carry and running zero: cleared on load, stepped on shift_a
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_r     <= '0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
        end else if (load_a) begin
            r_r     <= '0;
            r_carry <= w_sub;
            r_zacc  <= 1'b1;
        end else if (shift_a) begin
            r_r    <= {w_s, r_r[WIDTH-1:1]};
            r_zacc <= r_zacc & ~w_s;
            if (carry_en)
                r_carry <= w_cout;
        end
    end

    // output stage: snapshot result and flags, then shift out serially
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_o          <= '0;
            r_result     <= '0;
            r_carry_flag <= 1'b0;
            r_zero_flag  <= 1'b0;
        end else if (load_out) begin
            r_o          <= r_r;
            r_result     <= r_r;
            r_carry_flag <= r_carry;
            r_zero_flag  <= r_zacc;
        end else if (shift_out) begin
            r_o <= {1'b0, r_o[WIDTH-1:1]};
        end
    end

    assign result     = r_result;
    assign serial_out = r_o[0];
    assign carry_flag = r_carry_flag;
    assign zero_flag  = r_zero_flag;

endmodule

// File: tb/tb_serial_datapath.sv
// Self-checking bench for serial_datapath.
// Directed cases plus randomized ops against an arithmetic model.
module tb_serial_datapath;
    import cpu_pkg::*;

    localparam int W = 8;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] a_data = '0;
    logic [W-1:0] b_data = '0;
    logic [W-1:0] imm_data = '0;
    logic         load_a = 1'b0;
    logic         load_b = 1'b0;
    logic         shift_a = 1'b0;
    logic         shift_b = 1'b0;
    logic [1:0]   alu_op = '0;
    logic         carry_en = 1'b0;
    logic         load_out = 1'b0;
    logic         shift_out = 1'b0;
    logic [W-1:0] result;
    logic         serial_out;
    logic         carry_flag;
    logic         zero_flag;

    int n_checks = 0;
    int n_pass = 0;

    serial_datapath #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .opcode     (opcode),
        .a_data     (a_data),
        .b_data     (b_data),
        .imm_data   (imm_data),
        .load_a     (load_a),
        .load_b     (load_b),
        .shift_a    (shift_a),
        .shift_b    (shift_b),
        .alu_op     (alu_op),
        .carry_en   (carry_en),
        .load_out   (load_out),
        .shift_out  (shift_out),
        .result     (result),
        .serial_out (serial_out),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic. Returns {carry, result}.
    function automatic logic [W:0] model(input logic [3:0] op,
                                         input logic [1:0] alu,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic     sub;
        int       sum;
        sub = (op[2:0] == 3'b001);
        case (alu)
            2'b00: begin
                if (sub) begin
                    sum = int'(a) - int'(b);
                    return {(a >= b), sum[W-1:0]};
                end else begin
                    sum = int'(a) + int'(b);
                    return {(sum > int'(MASK)), sum[W-1:0]};
                end
            end
            2'b01:   return {sub, a ^ b};
            2'b10:   return {sub, a & b};
            default: return {sub, a | b};
        endcase
    endfunction

    // Full instruction sequence as the control FSM would issue it.
    task automatic run_op(input logic [3:0] op, input logic [1:0] alu,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic cen,
                          input logic ovl);
        @(negedge clk);
        opcode = op; alu_op = alu; carry_en = cen;
        a_data = a; b_data = b; imm_data = imm;
        load_a = 1'b1; shift_a = ovl; shift_b = ovl;
        @(negedge clk);
        load_a = 1'b0; shift_a = 1'b0; shift_b = 1'b0;
        if (op[3]) begin
            load_b = 1'b1;
            @(negedge clk);
            load_b = 1'b0;
        end
        shift_a = 1'b1; shift_b = 1'b1;
        repeat (W) @(negedge clk);
        shift_a = 1'b0; shift_b = 1'b0;
        load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({result, carry_flag, zero_flag, serial_out} !== '0)
            $display("FAIL reset: result=%h c=%b z=%b so=%b, want all 0",
                     result, carry_flag, zero_flag, serial_out);
        else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_add();
        run_op(OP_ADD, ALU_ADD, 8'h35, 8'h4A, 8'hFF, 1'b1, 1'b0);
        n_checks++;
        if ({result, carry_flag, zero_flag} !== {8'h7F, 1'b0, 1'b0})
            $display("FAIL add: result=%h c=%b z=%b, want 7f 0 0",
                     result, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_add_overflow();
        run_op(OP_ADD, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({result, carry_flag, zero_flag} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL add_ovf: result=%h c=%b z=%b, want 00 1 1",
                     result, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_sub();
        run_op(OP_SUB, ALU_ADD, 8'h10, 8'h01, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({result, carry_flag, zero_flag} !== {8'h0F, 1'b1, 1'b0})
            $display("FAIL sub_nb: result=%h c=%b z=%b, want 0f 1 0",
                     result, carry_flag, zero_flag);
        else n_pass++;
        run_op(OP_SUB, ALU_ADD, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({result, carry_flag, zero_flag} !== {8'hFF, 1'b0, 1'b0})
            $display("FAIL sub_brw: result=%h c=%b z=%b, want ff 0 0",
                     result, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_xori();
        // b_data holds junk; only the immediate may reach B
        run_op(OP_XORI, ALU_XOR, 8'hA5, 8'h33, 8'h0F, 1'b0, 1'b0);
        n_checks++;
        if ({result, zero_flag} !== {8'hAA, 1'b0})
            $display("FAIL xori: result=%h z=%b, want aa 0",
                     result, zero_flag);
        else n_pass++;
    endtask

    task automatic test_load_shift_overlap();
        // shift_a alongside load_a must not take an ALU step
        run_op(OP_ADD, ALU_ADD, 8'h21, 8'h12, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (result !== 8'h33)
            $display("FAIL overlap: result=%h, want 33", result);
        else n_pass++;
    endtask

    task automatic test_serial_out();
        logic [W-1:0] exp_bits;
        run_op(OP_ADD, ALU_ADD, 8'h90, 8'h06, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (result !== 8'h96)
            $display("FAIL ser_res: result=%h, want 96", result);
        else n_pass++;
        exp_bits = 8'h96;
        shift_out = 1'b1;
        for (int i = 0; i <= W; i++) begin
            n_checks++;
            if (serial_out !== ((i < W) ? exp_bits[i] : 1'b0))
                $display("FAIL ser_bit%0d: got %b, want %b", i, serial_out,
                         (i < W) ? exp_bits[i] : 1'b0);
            else n_pass++;
            @(negedge clk);
        end
        shift_out = 1'b0;
        n_checks++;
        if (result !== 8'h96)
            $display("FAIL ser_hold: result=%h, want 96", result);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opcode = OP_ADD; alu_op = ALU_ADD; carry_en = 1'b1;
        a_data = 8'h7E; b_data = 8'h55; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0; shift_a = 1'b1; shift_b = 1'b1;
        repeat (3) @(negedge clk);
        shift_a = 1'b0; shift_b = 1'b0;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({result, carry_flag, zero_flag, serial_out} !== '0)
            $display("FAIL rst_mid: result=%h c=%b z=%b so=%b, want 0",
                     result, carry_flag, zero_flag, serial_out);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        run_op(OP_ADD, ALU_ADD, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({result, carry_flag, zero_flag} !== {8'h02, 1'b0, 1'b0})
            $display("FAIL rst_fresh: result=%h c=%b z=%b, want 02 0 0",
                     result, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]   ops [10];
        logic [3:0]   op;
        logic [1:0]   alu;
        logic [W-1:0] a, b, imm, bop;
        logic [W:0]   exp;
        ops = '{OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR,
                OP_ADDI, OP_SUBI, OP_XORI, OP_ANDI, OP_ORI};
        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(0, 9)];
            alu = 2'($urandom_range(0, 3));
            a   = W'($urandom);
            b   = W'($urandom);
            imm = W'($urandom);
            if (i % 8 == 0) b = a;
            bop = op[3] ? b : imm;
            exp = model(op, alu, a, bop);
            run_op(op, alu, a, b, imm, (alu == ALU_ADD),
                   1'($urandom_range(0, 1)));
            n_checks++;
            if ({carry_flag, result, zero_flag} !==
                {exp, (exp[W-1:0] == '0)})
                $display("FAIL rand%0d op=%h alu=%0d a=%h b=%h: got r=%h c=%b z=%b, want r=%h c=%b z=%b",
                         i, op, alu, a, bop, result, carry_flag, zero_flag,
                         exp[W-1:0], exp[W], (exp[W-1:0] == '0));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_sub();
        test_xori();
        test_load_shift_overlap();
        test_serial_out();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
